// File: rtl/game_controller.sv
// game_controller: adventure-game room FSM with a sword-tracking FSM.
// The room register is one-hot and drives s0..s6 directly, so every output is
// registered. Direction buttons are priority-encoded N > S > E > W before the
// room logic sees them.
module game_controller (
  input  logic clk,
  input  logic reset,
  input  logic N,
  input  logic S,
  input  logic E,
  input  logic W,
  output logic s6,
  output logic s5,
  output logic s4,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic sw,
  output logic dead,
  output logic win
);

  // One-hot room encodings; bit i is output s<i>.
  localparam logic [6:0] CAVE   = 7'b000_0001;
  localparam logic [6:0] TUNNEL = 7'b000_0010;
  localparam logic [6:0] RIVER  = 7'b000_0100;
  localparam logic [6:0] STASH  = 7'b000_1000;
  localparam logic [6:0] DEN    = 7'b001_0000;
  localparam logic [6:0] VAULT  = 7'b010_0000;
  localparam logic [6:0] GRAVE  = 7'b100_0000;

  // Direction after priority resolution; at most one bit is set.
  typedef struct packed {
    logic n;
    logic s;
    logic e;
    logic w;
  } dir_t;

  logic [6:0] room, room_nxt;
  logic       sword;
  dir_t       dir;

  // Keep only the highest-priority asserted direction. Lower ones are dropped
  // even if the winner turns out to be an illegal exit.
  always_comb begin
    dir = '0;
    if (N)      dir.n = 1'b1;
    else if (S) dir.s = 1'b1;
    else if (E) dir.e = 1'b1;
    else if (W) dir.w = 1'b1;
  end

  // Room transitions; anything not listed is a stay.
  always_comb begin
    room_nxt = room;
    case (room)
      CAVE:   if (dir.e) room_nxt = TUNNEL;
      TUNNEL: begin
        if (dir.n)      room_nxt = CAVE;
        else if (dir.s) room_nxt = RIVER;
      end
      RIVER: begin
        if (dir.w)      room_nxt = STASH;
        else if (dir.e) room_nxt = DEN;
      end
      STASH:  if (dir.e) room_nxt = RIVER;
      // The den is a one-cycle stop; the outcome depends only on the sword.
      DEN:    room_nxt = sword ? VAULT : GRAVE;
      VAULT:  room_nxt = VAULT;
      GRAVE:  room_nxt = GRAVE;
      default: room_nxt = CAVE;
    endcase
  end

  // Room register; reset wins over any direction, from any room.
  always_ff @(posedge clk) begin
    if (reset) room <= CAVE;
    else       room <= room_nxt;
  end

  // Sword is picked up by spending an edge in the stash and kept until reset.
  always_ff @(posedge clk) begin
    if (reset)              sword <= 1'b0;
    else if (room == STASH) sword <= 1'b1;
  end

  assign {s6, s5, s4, s3, s2, s1, s0} = room;
  assign sw   = sword;
  assign dead = room[6];
  assign win  = room[5];

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: each applied cycle pushes the
// expected post-edge outputs, and a monitor pops and compares after the edge.
module tb_game_controller;

  logic clk = 1'b0;
  logic reset, N, S, E, W;
  logic s6, s5, s4, s3, s2, s1, s0, sw, dead, win;

  localparam logic [6:0] R0 = 7'b000_0001;
  localparam logic [6:0] R1 = 7'b000_0010;
  localparam logic [6:0] R2 = 7'b000_0100;
  localparam logic [6:0] R3 = 7'b000_1000;
  localparam logic [6:0] R4 = 7'b001_0000;
  localparam logic [6:0] R5 = 7'b010_0000;
  localparam logic [6:0] R6 = 7'b100_0000;

  // Direction codes for apply(): {N,S,E,W}
  localparam logic [3:0] D0 = 4'b0000;
  localparam logic [3:0] DN = 4'b1000;
  localparam logic [3:0] DS = 4'b0100;
  localparam logic [3:0] DE = 4'b0010;
  localparam logic [3:0] DW = 4'b0001;

  typedef struct {
    string      name;
    logic [6:0] room;
    logic       sw;
    logic       dead;
    logic       win;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  game_controller dut (
    .clk(clk), .reset(reset), .N(N), .S(S), .E(E), .W(W),
    .s6(s6), .s5(s5), .s4(s4), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
    .sw(sw), .dead(dead), .win(win)
  );

  always #5 clk = ~clk;

  // Monitor: compare outputs shortly after each edge against the scoreboard.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] rm;
      e  = q.pop_front();
      rm = {s6, s5, s4, s3, s2, s1, s0};
      checks++;
      if (rm !== e.room || sw !== e.sw || dead !== e.dead || win !== e.win) begin
        errors++;
        $display("FAIL %s: got room=%b sw=%b dead=%b win=%b, want room=%b sw=%b dead=%b win=%b",
                 e.name, rm, sw, dead, win, e.room, e.sw, e.dead, e.win);
      end
    end
  end

  // Drive one cycle of inputs (called at a negedge) and queue what must follow.
  task automatic apply(input string name, input logic rst, input logic [3:0] d,
                       input logic [6:0] room, input logic exp_sw);
    exp_t e;
    reset = rst;
    {N, S, E, W} = d;
    e.name = name;
    e.room = room;
    e.sw   = exp_sw;
    e.dead = (room == R6);
    e.win  = (room == R5);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset;
    apply("reset_a", 1'b1, DE, R0, 1'b0);
    apply("reset_b", 1'b1, DN, R0, 1'b0);
  endtask

  task automatic test_death_path;
    apply("dp_rst", 1'b1, D0, R0, 1'b0);
    apply("dp_e",   1'b0, DE, R1, 1'b0);
    apply("dp_s",   1'b0, DS, R2, 1'b0);
    apply("dp_e2",  1'b0, DE, R4, 1'b0);
    apply("dp_den", 1'b0, D0, R6, 1'b0);
    apply("dp_hE",  1'b0, DE, R6, 1'b0);
    apply("dp_hW",  1'b0, DW, R6, 1'b0);
    apply("dp_hN",  1'b0, DN, R6, 1'b0);
    // Reset must also escape the graveyard.
    apply("dp_out", 1'b1, DE, R0, 1'b0);
  endtask

  task automatic test_win_path;
    apply("wp_rst", 1'b1, D0, R0, 1'b0);
    apply("wp_e",   1'b0, DE, R1, 1'b0);
    apply("wp_s",   1'b0, DS, R2, 1'b0);
    apply("wp_w",   1'b0, DW, R3, 1'b0);
    apply("wp_e2",  1'b0, DE, R2, 1'b1);
    apply("wp_n",   1'b0, DN, R2, 1'b1);
    apply("wp_w2",  1'b0, DW, R3, 1'b1);
    apply("wp_e3",  1'b0, DE, R2, 1'b1);
    apply("wp_s2",  1'b0, DS, R2, 1'b1);
    apply("wp_e4",  1'b0, DE, R4, 1'b1);
    apply("wp_den", 1'b0, DW, R5, 1'b1);
    apply("wp_hld", 1'b0, DS, R5, 1'b1);
    apply("wp_out", 1'b1, DN, R0, 1'b0);
  endtask

  task automatic test_illegal;
    apply("il_rst", 1'b1, D0, R0, 1'b0);
    apply("il_n",   1'b0, DN, R0, 1'b0);
    apply("il_s",   1'b0, DS, R0, 1'b0);
    apply("il_w",   1'b0, DW, R0, 1'b0);
    apply("il_idl", 1'b0, D0, R0, 1'b0);
    apply("il_e",   1'b0, DE, R1, 1'b0);
    apply("il_tid", 1'b0, D0, R1, 1'b0);
    apply("il_s2",  1'b0, DS, R2, 1'b0);
    apply("il_w2",  1'b0, DW, R3, 1'b0);
    apply("il_stw", 1'b0, DW, R3, 1'b1);
    apply("il_stn", 1'b0, DN, R3, 1'b1);
  endtask

  task automatic test_priority;
    apply("pr_rst", 1'b1, D0, R0, 1'b0);
    apply("pr_e",   1'b0, DE, R1, 1'b0);
    apply("pr_ns",  1'b0, DN | DS, R0, 1'b0);
    apply("pr_e2",  1'b0, DE, R1, 1'b0);
    apply("pr_sw",  1'b0, DS | DW, R2, 1'b0);
    apply("pr_ne",  1'b0, DN | DE, R2, 1'b0);
    apply("pr_se",  1'b0, DS | DE, R2, 1'b0);
    apply("pr_ew",  1'b0, DE | DW, R4, 1'b0);
    apply("pr_den", 1'b0, DN | DS | DE | DW, R6, 1'b0);
  endtask

  task automatic test_mid_reset;
    apply("mr_rst", 1'b1, D0, R0, 1'b0);
    apply("mr_e",   1'b0, DE, R1, 1'b0);
    apply("mr_s",   1'b0, DS, R2, 1'b0);
    apply("mr_w",   1'b0, DW, R3, 1'b0);
    apply("mr_sw",  1'b0, D0, R3, 1'b1);
    apply("mr_rs2", 1'b1, DE, R0, 1'b0);
    apply("mr_e2",  1'b0, DE, R1, 1'b0);
    apply("mr_s2",  1'b0, DS, R2, 1'b0);
    apply("mr_e3",  1'b0, DE, R4, 1'b0);
    apply("mr_den", 1'b0, D0, R6, 1'b0);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {N, S, E, W} = 4'b0000;
    @(negedge clk);
    test_reset();
    test_death_path();
    test_win_path();
    test_illegal();
    test_priority();
    test_mid_reset();
    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
